coherence_bus_ctrl: RTL and testbench

COHERENCE_BUS_CTRL -- requirements
Module: coherence_bus_ctrl

---
 rtl/coherence_cache_pkg.sv | 35 +++
 rtl/coherence_rr_arb.sv | 42 ++++
 rtl/coherence_bus_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_cache_pkg.sv
// Shared coherence definitions: MESIF state indices, bus ops, snoop response
// bits and the bus controller FSM state type.
package coherence_cache_pkg;

  localparam int MESIF_BITS = 5;
  localparam int MESIF_F    = 0;
  localparam int MESIF_I    = 1;
  localparam int MESIF_S    = 2;
  localparam int MESIF_E    = 3;
  localparam int MESIF_M    = 4;

  localparam int              BUS_OP_BITS = 2;
  localparam logic [BUS_OP_BITS-1:0] BUS_NOP  = 2'd0;
  localparam logic [BUS_OP_BITS-1:0] BUS_RD   = 2'd1;
  localparam logic [BUS_OP_BITS-1:0] BUS_RDX  = 2'd2;
  localparam logic [BUS_OP_BITS-1:0] BUS_UPGR = 2'd3;

  localparam int BUS_RESP_BITS  = 3;
  localparam int LINE_EXIST_BIT = 0;
  localparam int FLUSH_BIT      = 1;
  localparam int FLUSH_OPT_BIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_RESOLVE,
    ST_MEM,
    ST_DONE
  } bus_state_t;

  function automatic logic [MESIF_BITS-1:0] mesif_onehot(input int idx);
    return MESIF_BITS'(1) << idx;
  endfunction

endpackage

// File: rtl/coherence_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past the
// winner whenever a grant is taken.
module coherence_rr_arb #(
  parameter int NUM_CORE = 4,
  parameter int PTR_W    = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CORE-1:0] req,
  input  logic                en,
  output logic [NUM_CORE-1:0] grant,
  output logic [PTR_W-1:0]    grant_idx
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_CORE; i++) begin
      cand = PTR_W'((int'(ptr_q) + i) % NUM_CORE);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en && found) begin
      ptr_q <= (grant_idx == PTR_W'(NUM_CORE - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping coherence bus controller: grants one core, snoops peers, resolves
// the MESI/MESIF fill state. Define COHERENCE_FORWARD_EN for MESIF forwarding.
module coherence_bus_ctrl
  import coherence_cache_pkg::*;
#(
  parameter int NUM_CORE     = 4,
  parameter int ADDR_W       = 32,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CORE-1:0]               req_valid,
  output logic [NUM_CORE-1:0]               req_ready,
  input  logic [NUM_CORE*BUS_OP_BITS-1:0]   req_op,
  input  logic [NUM_CORE*ADDR_W-1:0]        req_addr,
  output logic [NUM_CORE-1:0]               snp_valid,
  output logic [BUS_OP_BITS-1:0]            snp_op,
  output logic [ADDR_W-1:0]                 snp_addr,
  input  logic [NUM_CORE-1:0]               snp_resp_valid,
  input  logic [NUM_CORE*BUS_RESP_BITS-1:0] snp_resp,
  output logic                              mem_req,
  input  logic                              mem_ack,
  output logic [NUM_CORE-1:0]               cmp_valid,
  output logic [MESIF_BITS-1:0]             cmp_state,
  output logic                              cmp_peer_data,
  output logic                              cmp_timeout
);

  localparam int PTR_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);

  bus_state_t                 state_q, state_nxt;
  logic [NUM_CORE-1:0]        grant;
  logic [PTR_W-1:0]           grant_idx;
  logic                       arb_en, accept;
  logic [BUS_OP_BITS-1:0]     grant_op;
  logic [ADDR_W-1:0]          grant_addr;

  logic [PTR_W-1:0]           req_idx_q;
  logic [BUS_OP_BITS-1:0]     op_q;
  logic [ADDR_W-1:0]          addr_q;
  logic [NUM_CORE-1:0]        seen_q;
  logic [BUS_RESP_BITS-1:0]   resp_acc_q;
  logic [TMR_W-1:0]           timer_q;
  logic                       timeout_q;

  logic [NUM_CORE-1:0]        peer_mask, snp_pending, got;
  logic [BUS_RESP_BITS-1:0]   resp_now;
  logic                       all_seen, timer_expired, skip_snoop;
  logic                       peer_data, need_mem;

  function automatic logic [MESIF_BITS-1:0] resolve_state(
    input logic [BUS_OP_BITS-1:0] op,
    input logic                   exist
  );
    logic [MESIF_BITS-1:0] st;
    st = '0;
    case (op)
      BUS_RD: begin
        if (!exist) begin
          st = mesif_onehot(MESIF_E);
        end else begin
`ifdef COHERENCE_FORWARD_EN
          st = mesif_onehot(MESIF_F);
`else
          st = mesif_onehot(MESIF_S);
`endif
        end
      end
      BUS_RDX, BUS_UPGR: st = mesif_onehot(MESIF_M);
      default:           st = '0;
    endcase
    return st;
  endfunction

  assign arb_en = (state_q == ST_IDLE) && !rst;
  assign accept = arb_en && (|grant);

  coherence_rr_arb #(
    .NUM_CORE (NUM_CORE),
    .PTR_W    (PTR_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_op   = req_op[int'(grant_idx)*BUS_OP_BITS +: BUS_OP_BITS];
  assign grant_addr = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign skip_snoop = (NUM_CORE == 1) || (grant_op == BUS_NOP);

  // Snoop bookkeeping: a response only counts while its strobe is still up.
  always_comb begin
    peer_mask   = ~(NUM_CORE'(1) << req_idx_q);
    snp_pending = (state_q == ST_SNOOP) ? (peer_mask & ~seen_q) : '0;
    got         = snp_pending & snp_resp_valid;
    resp_now    = '0;
    for (int i = 0; i < NUM_CORE; i++) begin
      if (got[i]) resp_now = resp_now | snp_resp[i*BUS_RESP_BITS +: BUS_RESP_BITS];
    end
    all_seen      = (((seen_q | got) & peer_mask) == peer_mask);
    timer_expired = (timer_q == TMR_W'(RESP_TIMEOUT - 1)) && !all_seen;
    peer_data     = resp_acc_q[FLUSH_BIT] | resp_acc_q[FLUSH_OPT_BIT];
    need_mem      = ((op_q == BUS_RD) || (op_q == BUS_RDX)) && !peer_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    req_ready     = '0;
    snp_valid     = '0;
    snp_op        = '0;
    snp_addr      = '0;
    mem_req       = 1'b0;
    cmp_valid     = '0;
    cmp_state     = '0;
    cmp_peer_data = 1'b0;
    cmp_timeout   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          req_ready = grant;
          state_nxt = skip_snoop ? ST_RESOLVE : ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        snp_valid = snp_pending;
        snp_op    = op_q;
        snp_addr  = addr_q;
        if (all_seen || timer_expired) state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: state_nxt = need_mem ? ST_MEM : ST_DONE;
      ST_MEM: begin
        mem_req = 1'b1;
        if (mem_ack) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        cmp_valid     = NUM_CORE'(1) << req_idx_q;
        cmp_state     = resolve_state(op_q, resp_acc_q[LINE_EXIST_BIT]);
        cmp_peer_data = peer_data;
        cmp_timeout   = timeout_q;
        state_nxt     = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_idx_q  <= '0;
      seen_q     <= '0;
      resp_acc_q <= '0;
      timer_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_idx_q  <= grant_idx;
            seen_q     <= '0;
            resp_acc_q <= '0;
            timer_q    <= '0;
            timeout_q  <= 1'b0;
          end
        end
        ST_SNOOP: begin
          seen_q     <= seen_q | got;
          resp_acc_q <= resp_acc_q | resp_now;
          timer_q    <= timer_q + TMR_W'(1);
          if (timer_expired) timeout_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Request payload is only observed after acceptance, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= grant_op;
      addr_q <= grant_addr;
    end
  end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: directed transactions push expected
// grants/completions, a negedge monitor pops and compares.
module tb_coherence_bus_ctrl;
  import coherence_cache_pkg::*;

  localparam int NC = 4;
  localparam int AW = 32;

  localparam logic [MESIF_BITS-1:0] EXP_E = 5'b00001 << MESIF_E;
  localparam logic [MESIF_BITS-1:0] EXP_M = 5'b00001 << MESIF_M;
`ifdef COHERENCE_FORWARD_EN
  localparam logic [MESIF_BITS-1:0] EXP_RD_SHARED = 5'b00001 << MESIF_F;
`else
  localparam logic [MESIF_BITS-1:0] EXP_RD_SHARED = 5'b00001 << MESIF_S;
`endif

  logic                        clk = 1'b0;
  logic                        rst;
  logic [NC-1:0]               req_valid, req_ready, snp_valid, snp_resp_valid, cmp_valid;
  logic [NC*BUS_OP_BITS-1:0]   req_op;
  logic [NC*AW-1:0]            req_addr;
  logic [BUS_OP_BITS-1:0]      snp_op;
  logic [AW-1:0]               snp_addr;
  logic [NC*BUS_RESP_BITS-1:0] snp_resp;
  logic                        mem_req, mem_ack;
  logic [MESIF_BITS-1:0]       cmp_state;
  logic                        cmp_peer_data, cmp_timeout;

  logic [NC-1:0]               silent;
  logic [BUS_RESP_BITS-1:0]    resp_val [NC];
  logic                        mem_auto;
  int                          mem_delay;

  int vectors = 0, miscompares = 0;
  int cyc = 0, done_cnt = 0, grant_cyc = 0, cmp_cyc = 0, mem_cycles = 0, snp_cycles = 0;
  logic [NC-1:0] cur_mask;
  logic [AW-1:0] cur_addr;

  typedef struct packed {
    logic [NC-1:0]         cv;
    logic [MESIF_BITS-1:0] st;
    logic                  pd;
    logic                  to;
  } exp_t;

  exp_t          exp_q[$];
  logic [NC-1:0] gq[$];

  always #5 clk = ~clk;

  coherence_bus_ctrl #(.NUM_CORE(NC), .ADDR_W(AW), .RESP_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .snp_valid      (snp_valid),
    .snp_op         (snp_op),
    .snp_addr       (snp_addr),
    .snp_resp_valid (snp_resp_valid),
    .snp_resp       (snp_resp),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .cmp_valid      (cmp_valid),
    .cmp_state      (cmp_state),
    .cmp_peer_data  (cmp_peer_data),
    .cmp_timeout    (cmp_timeout)
  );

  // Peer caches answer in the same cycle they are snooped unless silenced.
  always_comb begin
    snp_resp_valid = snp_valid & ~silent;
    snp_resp       = '0;
    for (int i = 0; i < NC; i++) snp_resp[i*BUS_RESP_BITS +: BUS_RESP_BITS] = resp_val[i];
  end

  initial begin
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req && mem_auto && !rst) begin
        repeat (mem_delay) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (|req_ready) begin
          grant_cyc = cyc;
          cur_mask  = req_ready;
          for (int i = 0; i < NC; i++) if (req_ready[i]) cur_addr = req_addr[i*AW +: AW];
          if (gq.size() == 0) chk("grant_unexpected", req_ready, 0);
          else chk("grant", req_ready, gq.pop_front());
        end
        if (mem_req) mem_cycles++;
        if (|snp_valid) begin
          snp_cycles++;
          chk("snp_addr", snp_addr, cur_addr);
          chk("snp_excludes_requester", snp_valid & cur_mask, 0);
        end
        if (|cmp_valid) begin
          cmp_cyc = cyc;
          done_cnt++;
          if (exp_q.size() == 0) begin
            chk("cmp_unexpected", cmp_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("cmp_valid", cmp_valid, e.cv);
            chk("cmp_state", cmp_state, e.st);
            chk("cmp_peer_data", cmp_peer_data, e.pd);
            chk("cmp_timeout", cmp_timeout, e.to);
          end
        end
      end
    end
  end

  task automatic tick();
    logic [NC-1:0] g;
    @(negedge clk);
    g = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~g;
  endtask

  task automatic issue(input int c, input logic [BUS_OP_BITS-1:0] op, input logic [AW-1:0] a);
    req_valid[c]                             = 1'b1;
    req_op[c*BUS_OP_BITS +: BUS_OP_BITS]     = op;
    req_addr[c*AW +: AW]                     = a;
  endtask

  task automatic expect_txn(input int c, input logic [MESIF_BITS-1:0] st, input logic pd, input logic to);
    exp_t e;
    e.cv = NC'(1) << c;
    e.st = st;
    e.pd = pd;
    e.to = to;
    gq.push_back(NC'(1) << c);
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    chk("completion_within_budget", done_cnt >= target, 1);
  endtask

  int m0, s0, d0, n;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_addr  = '0;
    silent    = '0;
    for (int i = 0; i < NC; i++) resp_val[i] = '0;
    mem_auto  = 1'b1;
    mem_delay = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_snp_valid", snp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_state", cmp_state, 0);
    chk("rst_cmp_flags", {cmp_peer_data, cmp_timeout}, 0);
    rst = 1'b0;
    tick();

    // core1 read miss, memory acks two cycles after request
    m0 = mem_cycles;
    expect_txn(1, EXP_E, 1'b0, 1'b0);
    issue(1, BUS_RD, 32'h0000_1000);
    wait_done(1, 40);
    chk("rd_miss_mem_req_cycles", mem_cycles - m0, 3);
    chk("rd_miss_latency", cmp_cyc - grant_cyc, 6);

    // core0 read, core2 supplies the line
    resp_val[2] = 3'b101;
    m0 = mem_cycles;
    expect_txn(0, EXP_RD_SHARED, 1'b1, 1'b0);
    issue(0, BUS_RD, 32'h0000_2040);
    wait_done(2, 40);
    chk("peer_fill_no_mem_req", mem_cycles - m0, 0);
    chk("peer_fill_latency", cmp_cyc - grant_cyc, 3);
    resp_val[2] = '0;

    // core2 NOP skips the snoop phase
    s0 = snp_cycles;
    expect_txn(2, '0, 1'b0, 1'b0);
    issue(2, BUS_NOP, 32'h0000_3000);
    wait_done(3, 40);
    chk("nop_no_snoop", snp_cycles - s0, 0);
    chk("nop_latency", cmp_cyc - grant_cyc, 2);

    // core3 upgrade with peer1 silent -> timeout
    silent[1] = 1'b1;
    m0 = mem_cycles;
    s0 = snp_cycles;
    expect_txn(3, EXP_M, 1'b0, 1'b1);
    issue(3, BUS_UPGR, 32'h0000_4080);
    wait_done(4, 60);
    chk("upgr_no_mem_req", mem_cycles - m0, 0);
    chk("upgr_snoop_cycles", snp_cycles - s0, 16);
    chk("upgr_latency", cmp_cyc - grant_cyc, 18);
    silent[1] = 1'b0;

    // reset while waiting on memory aborts the transaction
    mem_auto = 1'b0;
    gq.push_back(4'b0010);
    issue(1, BUS_RD, 32'h0000_5000);
    n = 0;
    while (!mem_req && n < 20) begin
      tick();
      n++;
    end
    chk("abort_reached_mem", mem_req, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_mem_req_drops", mem_req, 0);
    chk("abort_cmp_valid", cmp_valid, 0);
    d0 = done_cnt;
    tick();
    tick();
    rst       = 1'b0;
    mem_auto  = 1'b1;
    mem_delay = 0;

    // all four at once from pointer 0, then core0 alone
    for (int c = 0; c < NC; c++) expect_txn(c, EXP_E, 1'b0, 1'b0);
    for (int c = 0; c < NC; c++) issue(c, BUS_RD, 32'h0000_6000 + 32'(c * 64));
    wait_done(d0 + 4, 120);
    expect_txn(0, EXP_E, 1'b0, 1'b0);
    issue(0, BUS_RD, 32'h0000_7000);
    wait_done(d0 + 5, 40);
    tick();
    tick();
    chk("total_completions", done_cnt, d0 + 5);
    chk("grant_queue_drained", gq.size(), 0);
    chk("cmp_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
